// File: rtl/phy_pkg.sv
// Shared phy definitions: idle word, slot timing defaults and the
// scheduler state encoding. Also used by phy_tx/phy_rx for idle detection.
package phy_pkg;

  localparam int unsigned SLOT_LEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF     = $clog2(SLOT_LEN_DEF);
  localparam logic [31:0] IDLE_WORD_DEF = 32'hBCBCBCBC;

  typedef enum logic {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // True when a received/transmitted word is the idle filler.
  function automatic logic is_idle(input logic [31:0] word);
    return word == IDLE_WORD_DEF;
  endfunction

endpackage

// File: rtl/phy_slot_cnt.sv
// Free-running word-slot counter.
// Ports:
//   clk_32f      - 32x word-rate clock
//   reset        - synchronous, active-high; forces cnt to 0
//   cnt_o        - position inside the current slot, 0..SLOT_LEN-1
//   slot_start_o - high while cnt_o == 0
//   boundary_o   - high while cnt_o == SLOT_LEN-1 (last cycle of a slot)
module phy_slot_cnt import phy_pkg::*; #(
  parameter int unsigned SLOT_LEN = SLOT_LEN_DEF,
  localparam int unsigned CNT_W   = $clog2(SLOT_LEN)
) (
  input  logic             clk_32f,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt_o,
  output logic             slot_start_o,
  output logic             boundary_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // SLOT_LEN is a power of two, so the natural wrap of the adder is the
  // slot wrap; no compare-and-clear is needed.
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_32f) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o        = cnt_q;
  assign slot_start_o = (cnt_q == '0);
  assign boundary_o   = (cnt_q == CNT_W'(SLOT_LEN - 1));

endmodule

// File: rtl/phy_tx_sched.sv
// Word-slot scheduler in front of the phy transmitter. Two word sources
// share the 32-bit phy input under round-robin arbitration; each granted
// word occupies exactly one slot. After reset TRAIN_WORDS idle slots are
// sent before arbitration begins.
// Ports:
//   clk_32f, reset           - clock and synchronous active-high reset
//   data0_in/valid0_in       - source 0 word and request
//   ready0_out               - source 0 accepted this cycle
//   data1_in/valid1_in       - source 1 word and request
//   ready1_out               - source 1 accepted this cycle
//   data_out/valid_out       - word and valid to the phy
//   slot_start               - first cycle of every slot
//   src_out                  - source of the word in the current slot
//   training                 - high while the preamble is being sent
module phy_tx_sched import phy_pkg::*; #(
  parameter int unsigned SLOT_LEN    = SLOT_LEN_DEF,
  parameter int unsigned TRAIN_WORDS = 4,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data0_in,
  input  logic        valid0_in,
  output logic        ready0_out,
  input  logic [31:0] data1_in,
  input  logic        valid1_in,
  output logic        ready1_out,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        slot_start,
  output logic        src_out,
  output logic        training
);

  localparam int unsigned CNT_W   = $clog2(SLOT_LEN);
  localparam int unsigned TRAIN_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

  logic [CNT_W-1:0]   cnt_unused;  // slot phase beyond start/boundary is not needed here
  logic               boundary;
  tx_state_e          state_q;
  logic [TRAIN_W-1:0] train_cnt_q;
  logic [31:0]        data_q;
  logic               valid_q;
  logic               src_q;
  logic               last_grant_q;
  logic               train_last;
  logic               arb_en;
  logic               grant0;
  logic               grant1;

  phy_slot_cnt #(
    .SLOT_LEN(SLOT_LEN)
  ) u_slot_cnt (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .cnt_o       (cnt_unused),
    .slot_start_o(slot_start),
    .boundary_o  (boundary)
  );

  // The last training boundary already arbitrates, so the first word lands
  // in the slot right after the preamble.
  assign train_last = (state_q == ST_TRAIN) &&
                      (train_cnt_q == TRAIN_W'(TRAIN_WORDS - 1));

  // Reset gates the grant so readys stay low on a boundary that is aborted.
  assign arb_en = boundary && !reset && ((state_q == ST_ACTIVE) || train_last);

  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (arb_en) begin
      if (valid0_in && valid1_in) begin
        // Contention: the source that did not win last time goes now.
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = valid0_in;
        grant1 = valid1_in;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q      <= ST_TRAIN;
      train_cnt_q  <= '0;
      data_q       <= IDLE_WORD;
      valid_q      <= 1'b0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (boundary) begin
      if (state_q == ST_TRAIN) begin
        if (train_last) state_q     <= ST_ACTIVE;
        else            train_cnt_q <= train_cnt_q + TRAIN_W'(1);
      end
      if (grant0) begin
        data_q       <= data0_in;
        valid_q      <= 1'b1;
        src_q        <= 1'b0;
        last_grant_q <= 1'b0;
      end else if (grant1) begin
        data_q       <= data1_in;
        valid_q      <= 1'b1;
        src_q        <= 1'b1;
        last_grant_q <= 1'b1;
      end else begin
        // Empty slot: src and fairness history are kept.
        data_q  <= IDLE_WORD;
        valid_q <= 1'b0;
      end
    end
  end

  assign ready0_out = grant0;
  assign ready1_out = grant1;
  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign src_out    = src_q;
  assign training   = (state_q == ST_TRAIN);

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: training preamble, single source,
// contention, empty-slot gap, off-boundary valid and mid-slot reset.
module tb_phy_tx_sched;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;
  localparam int ON_LO = 0, ON_HI = 31, OFF_LO = 1, OFF_HI = 0;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] data0_in = '0;
  logic        valid0_in = 1'b0;
  logic        ready0_out;
  logic [31:0] data1_in = '0;
  logic        valid1_in = 1'b0;
  logic        ready1_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        slot_start;
  logic        src_out;
  logic        training;

  int total = 0;
  int bad   = 0;
  int cur_slot = 0;
  int cur_cyc  = 0;

  phy_tx_sched dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data0_in  (data0_in),
    .valid0_in (valid0_in),
    .ready0_out(ready0_out),
    .data1_in  (data1_in),
    .valid1_in (valid1_in),
    .ready1_out(ready1_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .slot_start(slot_start),
    .src_out   (src_out),
    .training  (training)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s slot=%0d cyc=%0d got=%h exp=%h", tag, cur_slot, cur_cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  // Hold reset for n edges, checking the reset state after each one.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      cur_cyc = -1;
      check("rst_data",  data_out, IDLE);
      check("rst_valid", valid_out, 1'b0);
      check("rst_src",   src_out, 1'b0);
      check("rst_train", training, 1'b1);
      check("rst_start", slot_start, 1'b1);
      check("rst_rdy0",  ready0_out, 1'b0);
      check("rst_rdy1",  ready1_out, 1'b0);
    end
    reset = 1'b0;
    cur_slot = 0;
  endtask

  // Run ncyc cycles of one slot starting at cnt==0: expected outputs are
  // constant over the slot, valids are high inside [lo,hi], and a ready is
  // expected only on the boundary cycle.
  task automatic run_slot(input int ncyc,
                          input logic [31:0] e_data, input logic e_valid,
                          input logic e_src, input logic e_train,
                          input logic [31:0] d0, input int v0_lo, input int v0_hi,
                          input logic [31:0] d1, input int v1_lo, input int v1_hi,
                          input logic e_r0, input logic e_r1);
    for (int c = 0; c < ncyc; c++) begin
      data0_in  = d0;
      valid0_in = (c >= v0_lo) && (c <= v0_hi);
      data1_in  = d1;
      valid1_in = (c >= v1_lo) && (c <= v1_hi);
      #1;
      cur_cyc = c;
      check("data",  data_out, e_data);
      check("valid", valid_out, e_valid);
      check("src",   src_out, e_src);
      check("train", training, e_train);
      check("start", slot_start, c == 0);
      check("rdy0",  ready0_out, (c == 31) && e_r0);
      check("rdy1",  ready1_out, (c == 31) && e_r1);
      tick();
    end
    cur_slot++;
  endtask

  initial begin
    // 1: preamble with no sources, then idle in ACTIVE.
    do_reset(4);
    for (int s = 0; s < 6; s++)
      run_slot(32, IDLE, 0, 0, s < 4, '0, OFF_LO, OFF_HI, '0, OFF_LO, OFF_HI, 0, 0);

    // 2: source 0 requesting from reset release; readys stay low in reset.
    data0_in = 32'hFFFFFFFF; valid0_in = 1'b1;
    do_reset(4);
    for (int s = 0; s < 4; s++)
      run_slot(32, IDLE, 0, 0, 1, 32'hFFFFFFFF, ON_LO, ON_HI, '0, OFF_LO, OFF_HI, s == 3, 0);
    run_slot(32, 32'hFFFFFFFF, 1, 0, 0, 32'hEEEEEEEE, ON_LO, ON_HI, '0, OFF_LO, OFF_HI, 1, 0);
    run_slot(32, 32'hEEEEEEEE, 1, 0, 0, '0, OFF_LO, OFF_HI, '0, OFF_LO, OFF_HI, 0, 0);

    // 3: both sources continuously; last winner was 0, so 1 goes first.
    run_slot(32, IDLE,         0, 0, 0, 32'hDDDDDDDD, ON_LO, ON_HI, 32'hCCCCCCCC, ON_LO, ON_HI, 0, 1);
    run_slot(32, 32'hCCCCCCCC, 1, 1, 0, 32'hDDDDDDDD, ON_LO, ON_HI, 32'hCCCCCCCC, ON_LO, ON_HI, 1, 0);
    run_slot(32, 32'hDDDDDDDD, 1, 0, 0, 32'hDDDDDDDD, ON_LO, ON_HI, 32'hCCCCCCCC, ON_LO, ON_HI, 0, 1);
    run_slot(32, 32'hCCCCCCCC, 1, 1, 0, 32'hDDDDDDDD, ON_LO, ON_HI, 32'hCCCCCCCC, ON_LO, ON_HI, 1, 0);

    // 4: source 1 BBBB, gap slot, then contention must favour source 0
    //    (last grant still 1) while AAAA waits one more slot.
    run_slot(32, 32'hDDDDDDDD, 1, 0, 0, '0, OFF_LO, OFF_HI, 32'hBBBBBBBB, ON_LO, ON_HI, 0, 1);
    run_slot(32, 32'hBBBBBBBB, 1, 1, 0, '0, OFF_LO, OFF_HI, '0, OFF_LO, OFF_HI, 0, 0);
    run_slot(32, IDLE,         0, 1, 0, 32'h99999999, ON_LO, ON_HI, 32'hAAAAAAAA, ON_LO, ON_HI, 1, 0);
    run_slot(32, 32'h99999999, 1, 0, 0, 32'h99999999, ON_LO, ON_HI, 32'hAAAAAAAA, ON_LO, ON_HI, 0, 1);

    // 5: valid0 only during cnt 5..20 -> never granted.
    run_slot(32, 32'hAAAAAAAA, 1, 1, 0, 32'h11111111, 5, 20, '0, OFF_LO, OFF_HI, 0, 0);
    run_slot(32, IDLE,         0, 1, 0, 32'hEEEEEEEE, ON_LO, ON_HI, '0, OFF_LO, OFF_HI, 1, 0);

    // 6: reset at cnt 17 of the EEEE slot, then a full preamble again.
    run_slot(17, 32'hEEEEEEEE, 1, 0, 0, '0, OFF_LO, OFF_HI, '0, OFF_LO, OFF_HI, 0, 0);
    data0_in = 32'h12345678; valid0_in = 1'b1;
    do_reset(1);
    for (int s = 0; s < 4; s++)
      run_slot(32, IDLE, 0, 0, 1, 32'h12345678, ON_LO, ON_HI, '0, OFF_LO, OFF_HI, s == 3, 0);
    run_slot(32, 32'h12345678, 1, 0, 0, '0, OFF_LO, OFF_HI, '0, OFF_LO, OFF_HI, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
